// File: rtl/rnd_range_gen_if.sv
// Request/response handshake bundle for rnd_range_gen: the range request goes in,
// the bounded random result comes back.
interface rnd_range_gen_if #(
  parameter int unsigned OUT_W = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [OUT_W-1:0] req_lo;
  logic [OUT_W-1:0] req_hi;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [OUT_W-1:0] rsp_data;
  logic             rsp_fallback;

  modport master (
    output req_valid, req_lo, req_hi, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_fallback
  );

  modport slave (
    input  req_valid, req_lo, req_hi, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_fallback
  );
endinterface

// File: rtl/rnd_range_gen.sv
// Galois-LFSR bounded random source: a power-of-two mask plus rejection sampling,
// with a retry cap that falls back to a deterministic in-range fold.
module rnd_range_gen #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned TAPS      = 32'h0000_B400,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned MAX_TRIES = 8,
  parameter int unsigned SEED_INIT = 1,
  parameter bit          FREE_RUN  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lock_seed,
  rnd_range_gen_if.slave   bus,
  output logic [WIDTH-1:0] lfsr_state
);
  localparam logic [WIDTH-1:0] TAP_MASK = WIDTH'(TAPS);
  localparam logic [WIDTH-1:0] SEED_RAW = WIDTH'(SEED_INIT);
  localparam logic [WIDTH-1:0] SEED     = (SEED_RAW == '0) ? WIDTH'(1) : SEED_RAW;
  localparam int unsigned      TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  typedef enum logic [1:0] {IDLE, MASK, GEN, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] lfsr_next;
  logic [WIDTH-1:0] seed_cnt;
  logic [TRY_W-1:0] tries;
  logic [OUT_W-1:0] lo;
  logic [OUT_W-1:0] span;
  logic [OUT_W-1:0] mask;
  logic [OUT_W-1:0] cand;
  logic [OUT_W-1:0] in_lo;
  logic [OUT_W-1:0] in_hi;
  logic             accept;
  logic             last_try;
  logic             req_ready;
  logic             rsp_valid;
  logic [OUT_W-1:0] rsp_data;
  logic             rsp_fallback;

  // Smear the top set bit downward: smallest 2^k-1 covering the span.
  function automatic logic [OUT_W-1:0] cover_mask(input logic [OUT_W-1:0] v);
    logic [OUT_W-1:0] m;
    m = v;
    for (int unsigned i = 1; i < OUT_W; i++) begin
      m = m | (m >> i);
    end
    return m;
  endfunction

  assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ TAP_MASK) : (lfsr >> 1);
  assign cand      = lfsr[OUT_W-1:0] & mask;
  assign accept    = (cand <= span);
  assign last_try  = (tries == TRY_W'(MAX_TRIES - 1));
  assign in_lo     = (bus.req_lo <= bus.req_hi) ? bus.req_lo : bus.req_hi;
  assign in_hi     = (bus.req_lo <= bus.req_hi) ? bus.req_hi : bus.req_lo;

  assign bus.req_ready    = req_ready;
  assign bus.rsp_valid    = rsp_valid;
  assign bus.rsp_data     = rsp_data;
  assign bus.rsp_fallback = rsp_fallback;
  assign lfsr_state       = lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      lfsr         <= SEED;
      seed_cnt     <= '0;
      tries        <= '0;
      lo           <= '0;
      span         <= '0;
      mask         <= '0;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_fallback <= 1'b0;
    end else begin
      seed_cnt <= seed_cnt + 1'b1;

      if (lock_seed) begin
        lfsr <= (seed_cnt == '0) ? WIDTH'(1) : seed_cnt;
      end else if (state == GEN || FREE_RUN) begin
        lfsr <= lfsr_next;
      end

      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lo        <= in_lo;
            span      <= in_hi - in_lo;
            tries     <= '0;
            req_ready <= 1'b0;
            state     <= MASK;
          end
        end
        MASK: begin
          mask  <= cover_mask(span);
          state <= GEN;
        end
        GEN: begin
          if (accept) begin
            rsp_data     <= lo + cand;
            rsp_fallback <= 1'b0;
            rsp_valid    <= 1'b1;
            state        <= HOLD;
          end else if (last_try) begin
            // mask < 2*(span+1), so subtracting span+1 folds back into [lo, hi]
            rsp_data     <= lo + cand - span - 1'b1;
            rsp_fallback <= 1'b1;
            rsp_valid    <= 1'b1;
            state        <= HOLD;
          end else begin
            tries <= tries + 1'b1;
          end
        end
        HOLD: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rnd_range_gen.sv
// Randomised self-checking bench for rnd_range_gen: three instances (default,
// single-try, free-running) against a per-request behavioural model.
module tb_rnd_range_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lock_seed = 1'b0;
  logic       req_valid = 1'b0;
  logic       rsp_ready = 1'b1;
  logic [7:0] req_lo = '0;
  logic [7:0] req_hi = '0;

  always #5 clk = ~clk;

  rnd_range_gen_if #(.OUT_W(8)) if0 ();
  rnd_range_gen_if #(.OUT_W(8)) if1 ();
  rnd_range_gen_if #(.OUT_W(8)) if2 ();

  assign if0.req_valid = req_valid;
  assign if0.req_lo    = req_lo;
  assign if0.req_hi    = req_hi;
  assign if0.rsp_ready = rsp_ready;
  assign if1.req_valid = req_valid;
  assign if1.req_lo    = req_lo;
  assign if1.req_hi    = req_hi;
  assign if1.rsp_ready = rsp_ready;
  assign if2.req_valid = req_valid;
  assign if2.req_lo    = req_lo;
  assign if2.req_hi    = req_hi;
  assign if2.rsp_ready = rsp_ready;

  logic [15:0] st0, st1, st2;

  rnd_range_gen #(.MAX_TRIES(8)) u0 (
    .clk(clk), .rst(rst), .lock_seed(lock_seed), .bus(if0), .lfsr_state(st0));
  rnd_range_gen #(.MAX_TRIES(1)) u1 (
    .clk(clk), .rst(rst), .lock_seed(lock_seed), .bus(if1), .lfsr_state(st1));
  rnd_range_gen #(.MAX_TRIES(8), .FREE_RUN(1'b1)) u2 (
    .clk(clk), .rst(rst), .lock_seed(lock_seed), .bus(if2), .lfsr_state(st2));

  int errors = 0;
  int checks = 0;

  // Cycles since reset release: what the seed counter is expected to hold.
  logic [15:0] cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt + 16'd1;
  end

  logic [15:0] m_s0, m_s1;
  bit          cover_on = 1'b0;
  bit          hit [0:255];
  int          r_lat0, r_lat1;
  logic [7:0]  r_dat0, r_dat1;
  logic        r_fb0, r_fb1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Draw samples per the rejection rule until accept or the try cap.
  function automatic void model(input logic [15:0] s_in, input logic [7:0] a, input logic [7:0] b,
                                input int maxt, output logic [7:0] d, output logic fb,
                                output int gens, output logic [15:0] s_out);
    int l, sp, m, c;
    logic [15:0] s;
    bit done;
    l = (a < b) ? int'(a) : int'(b);
    sp = ((a < b) ? int'(b) : int'(a)) - l;
    m = 0;
    while (m < sp) m = m * 2 + 1;
    s = s_in; done = 1'b0; d = '0; fb = 1'b0; gens = 0;
    for (int k = 0; k < maxt && !done; k++) begin
      c = int'(s[7:0]) & m;
      gens = k + 1;
      s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
      if (c <= sp) begin
        d = 8'(l + c); fb = 1'b0; done = 1'b1;
      end else if (k == maxt - 1) begin
        d = 8'(l + c - (sp + 1)); fb = 1'b1; done = 1'b1;
      end
    end
    s_out = s;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2 rst = 1'b0;
    m_s0 = 16'h0001;
    m_s1 = 16'h0001;
  endtask

  // Call during the low clock phase; the counter value now is what gets loaded.
  task automatic pulse_lock();
    logic [15:0] e;
    e = (cnt == 16'd0) ? 16'd1 : cnt;
    lock_seed = 1'b1;
    @(posedge clk);
    #1 lock_seed = 1'b0;
    m_s0 = e;
    m_s1 = e;
    chk("lock_u0", st0, e);
  endtask

  task automatic do_req(input logic [7:0] a, input logic [7:0] b);
    logic [7:0]  ed0, ed1, d0, d1, d2, lo_b, hi_b;
    logic        ef0, ef1, f0, f1;
    int          g0, g1, lat0, lat1, lat2;
    logic [15:0] es0, es1;
    model(m_s0, a, b, 8, ed0, ef0, g0, es0);
    model(m_s1, a, b, 1, ed1, ef1, g1, es1);
    lo_b = (a < b) ? a : b;
    hi_b = (a < b) ? b : a;
    lat0 = -1; lat1 = -1; lat2 = -1;
    d0 = '0; d1 = '0; d2 = '0; f0 = 1'b0; f1 = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_lo = a; req_hi = b;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) chk("busy_ready", if0.req_ready, 0);
      if (lat0 < 0 && if0.rsp_valid) begin lat0 = n; d0 = if0.rsp_data; f0 = if0.rsp_fallback; end
      if (lat1 < 0 && if1.rsp_valid) begin lat1 = n; d1 = if1.rsp_data; f1 = if1.rsp_fallback; end
      if (lat2 < 0 && if2.rsp_valid) begin lat2 = n; d2 = if2.rsp_data; end
    end
    chk("u0_lat", lat0, 1 + g0);
    chk("u0_data", d0, ed0);
    chk("u0_fb", f0, ef0);
    chk("u0_lfsr", st0, es0);
    chk("u1_lat", lat1, 1 + g1);
    chk("u1_data", d1, ed1);
    chk("u1_fb", f1, ef1);
    chk("u1_lfsr", st1, es1);
    chk("u2_seen", lat2 > 0, 1);
    chk("u2_range", (d2 >= lo_b) && (d2 <= hi_b), 1);
    chk("idle_ready", if0.req_ready, 1);
    if (cover_on) hit[d2] = 1'b1;
    m_s0 = es0; m_s1 = es1;
    r_lat0 = lat0; r_dat0 = d0; r_fb0 = f0;
    r_lat1 = lat1; r_dat1 = d1; r_fb1 = f1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  hd;
    logic        hf;
    logic [15:0] hs;
    int          hg, miss, guard;

    // Reset values
    #12;
    chk("rst_ready", if0.req_ready, 1);
    chk("rst_valid", if0.rsp_valid, 0);
    chk("rst_data", if0.rsp_data, 0);
    chk("rst_fb", if0.rsp_fallback, 0);
    chk("rst_lfsr", st0, 16'h0001);
    do_reset();

    // Full range from seed 1, then a degenerate single-value range
    do_req(8'd0, 8'd255);
    chk("t1_data", r_dat0, 8'h01);
    chk("t1_fb", r_fb0, 0);
    chk("t1_lat", r_lat0, 2);
    chk("t1_lfsr", st0, 16'hB400);
    do_req(8'd10, 8'd10);
    chk("t1b_data", r_dat0, 8'd10);
    chk("t1b_lfsr", st0, 16'h5A00);

    // Seed from counter value 7, one rejection (u0) vs. immediate fallback (u1)
    do_reset();
    guard = 0;
    while (cnt != 16'd7 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    pulse_lock();
    chk("t2_lock", st0, 16'h0007);
    do_req(8'd0, 8'd4);
    chk("t2_data", r_dat0, 8'd3);
    chk("t2_fb", r_fb0, 0);
    chk("t2_lat", r_lat0, 3);
    chk("t3_data", r_dat1, 8'd2);
    chk("t3_fb", r_fb1, 1);
    chk("t3_lat", r_lat1, 2);

    // Response held under back-pressure
    do_reset();
    model(m_s0, 8'd0, 8'd255, 8, hd, hf, hg, hs);
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_lo = 8'd0; req_hi = 8'd255;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 chk("h_early", if0.rsp_valid, 0);
    @(posedge clk);
    #1 chk("h_valid", if0.rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("h_valid_hold", if0.rsp_valid, 1);
      chk("h_data", if0.rsp_data, hd);
      chk("h_fb", if0.rsp_fallback, hf);
      chk("h_ready", if0.req_ready, 0);
      chk("h_lfsr", st0, hs);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("h_rel_ready", if0.req_ready, 1);
    chk("h_rel_valid", if0.rsp_valid, 0);
    m_s0 = hs; m_s1 = hs;

    // Reset while in GEN, then lock with the counter at zero
    @(negedge clk);
    pulse_lock();
    @(negedge clk);
    req_valid = 1'b1; req_lo = 8'd0; req_hi = 8'd4;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rg_valid", if0.rsp_valid, 0);
    chk("rg_ready", if0.req_ready, 1);
    chk("rg_lfsr", st0, 16'h0001);
    @(negedge clk);
    #1 rst = 1'b0;
    m_s0 = 16'h0001; m_s1 = 16'h0001;
    pulse_lock();
    chk("lock0", st0, 16'h0001);

    // Random ranges with occasional reseeding
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(7) == 0) begin
        @(negedge clk);
        pulse_lock();
      end
      repeat ($urandom_range(3)) @(posedge clk);
      do_req(8'($urandom), 8'($urandom));
    end

    // Swapped bounds, free-running source must cover the whole range
    cover_on = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(3)) @(posedge clk);
      do_req(8'd200, 8'd100);
    end
    miss = 0;
    for (int v = 100; v <= 200; v++) if (!hit[v]) miss++;
    chk("u2_cover_missing", miss, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
